// File: rtl/mam_pkg.sv
// rtl/mam_pkg.sv - shared MAM request types, constants and helpers
package mam_pkg;

    localparam int MAM_BEATS_W = 14;
    localparam int MAM_ADDR_W  = 32;

    typedef struct packed {
        logic                   rw;
        logic [MAM_ADDR_W-1:0]  addr;
        logic                   burst;
        logic [MAM_BEATS_W-1:0] beats;
    } mam_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } mam_sram_state_t;

    // A burst of zero beats still moves one word.
    function automatic logic [MAM_BEATS_W-1:0] mam_beat_count(
        input logic                   burst,
        input logic [MAM_BEATS_W-1:0] beats
    );
        if (burst && (beats != '0)) begin
            return beats;
        end
        return MAM_BEATS_W'(1);
    endfunction

endpackage

// File: rtl/mam_sram_adapter_if.sv
// rtl/mam_sram_adapter_if.sv - MAM request/write/read handshake bundle
interface mam_sram_adapter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) ();
    import mam_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_burst;
    logic [MAM_BEATS_W-1:0]  req_beats;

    logic                    write_valid;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic                    write_ready;

    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
        output write_valid, write_data, write_strb,
        output read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
        input  write_valid, write_data, write_strb,
        input  read_ready,
        output req_ready, write_ready, read_valid, read_data
    );

endinterface

// File: rtl/mam_sram_rdfifo.sv
// rtl/mam_sram_rdfifo.sv - 2-entry read-data FIFO with reset flush
module mam_sram_rdfifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != 2'd0);
    assign valid  = (count != 2'd0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mam_sram_adapter.sv
// rtl/mam_sram_adapter.sv - MAM to single-port synchronous SRAM adapter
module mam_sram_adapter
    import mam_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    SRAM_AW    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    mam_sram_adapter_if.slave       mam,
    output logic                    sram_ce,
    output logic                    sram_we,
    output logic [SRAM_AW-1:0]      sram_addr,
    output logic [DATA_WIDTH/8-1:0] sram_be,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    mam_sram_state_t        state;
    mam_sram_state_t        state_next;
    logic [SRAM_AW-1:0]     word_addr;
    logic [MAM_BEATS_W-1:0] beats_left;
    logic                   rd_inflight;

    logic [ADDR_WIDTH-1:0]  byte_off;
    logic [SRAM_AW-1:0]     req_word;
    logic                   accept;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   last_beat;
    logic                   credit_ok;
    logic [2:0]             occ;

    logic                   fifo_valid;
    logic                   fifo_pop;
    logic [1:0]             fifo_count;
    logic [DATA_WIDTH-1:0]  fifo_head;

    assign byte_off  = mam.req_addr - BASE_ADDR;
    assign req_word  = SRAM_AW'(byte_off >> BYTE_SHIFT);
    assign last_beat = (beats_left == MAM_BEATS_W'(1));

    assign mam.req_ready   = (state == ST_IDLE) && !rst;
    assign mam.write_ready = (state == ST_WRITE) && !rst;
    assign mam.read_valid  = fifo_valid && !rst;
    assign mam.read_data   = fifo_head;

    assign accept   = mam.req_ready && mam.req_valid;
    assign wr_fire  = mam.write_ready && mam.write_valid;
    assign fifo_pop = mam.read_valid && mam.read_ready;

    // Occupancy is counted after this cycle's pop so a draining FIFO keeps one read per cycle.
    assign occ       = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
    assign credit_ok = (occ < 3'd2);
    assign rd_fire   = (state == ST_READ) && credit_ok && !rst;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = mam.req_rw ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_fire && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_fire && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_ce   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_be   = '0;
        sram_din  = '0;
        if (wr_fire) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = word_addr;
            sram_be   = mam.write_strb;
            sram_din  = mam.write_data;
        end else if (rd_fire) begin
            sram_ce   = 1'b1;
            sram_addr = word_addr;
            sram_be   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_addr   <= '0;
            beats_left  <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_next;
            rd_inflight <= rd_fire;
            if (accept) begin
                word_addr  <= req_word;
                beats_left <= mam_beat_count(mam.req_burst, mam.req_beats);
            end else if (wr_fire || rd_fire) begin
                word_addr  <= word_addr + SRAM_AW'(1);
                beats_left <= beats_left - MAM_BEATS_W'(1);
            end
        end
    end

    mam_sram_rdfifo #(
        .WIDTH(DATA_WIDTH)
    ) u_rdfifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_inflight),
        .push_data(sram_dout),
        .pop      (fifo_pop),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_mam_sram_adapter.sv
// tb/tb_mam_sram_adapter.sv - self-checking bench for mam_sram_adapter
module tb_mam_sram_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_ce;
    logic        sram_we;
    logic [3:0]  sram_addr;
    logic [1:0]  sram_be;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;

    logic [15:0] mem [16];
    logic [15:0] dout_q;

    int errors = 0;
    int checks = 0;

    logic        log_we   [$];
    logic [3:0]  log_addr [$];
    logic [15:0] log_din  [$];

    mam_sram_adapter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

    mam_sram_adapter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32),
        .BASE_ADDR (32'h0),
        .SRAM_AW   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mam      (bus),
        .sram_ce  (sram_ce),
        .sram_we  (sram_we),
        .sram_addr(sram_addr),
        .sram_be  (sram_be),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Byte-enabled SRAM with one-cycle read latency; cleared while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
            dout_q <= 16'h0;
        end else if (sram_ce && sram_we) begin
            for (int b = 0; b < 2; b++)
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
        end else if (sram_ce) begin
            dout_q <= mem[sram_addr];
        end
    end
    assign sram_dout = dout_q;

    always @(negedge clk) begin
        if (sram_ce) begin
            log_we.push_back(sram_we);
            log_addr.push_back(sram_addr);
            log_din.push_back(sram_din);
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  strb;
        logic [3:0]  exp_addr;
        logic [15:0] exp_mem;
    } wvec_t;

    wvec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_din.delete();
    endtask

    task automatic start_req(input logic rw, input logic [31:0] addr, input int n);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_burst = 1'b1;
        bus.req_beats = 14'(n);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic burst_write(input logic [31:0] addr, input int n, input logic [15:0] d0,
                               input int stall_at);
        bus.write_valid = 1'b0;
        start_req(1'b1, addr, n);
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                bus.write_valid = 1'b0;
                repeat (3) tick();
            end
            bus.write_valid = 1'b1;
            bus.write_data  = d0 + 16'(b);
            bus.write_strb  = 2'b11;
            tick();
        end
        bus.write_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd [8];
        int          got;

        vecs[0] = '{32'h10, 16'h000F, 2'b11, 4'h8, 16'h000F};
        vecs[1] = '{32'h04, 16'h1234, 2'b11, 4'h2, 16'h1234};
        vecs[2] = '{32'h05, 16'hBEEF, 2'b01, 4'h2, 16'h12EF};
        vecs[3] = '{32'h06, 16'hBEEF, 2'b10, 4'h3, 16'hBE00};
        vecs[4] = '{32'h3E, 16'hCAFE, 2'b11, 4'hF, 16'hCAFE};
        vecs[5] = '{32'h20, 16'h5A5A, 2'b00, 4'h0, 16'h0000};

        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_rw      = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_burst   = 1'b0;
        bus.req_beats   = 14'h0;
        bus.write_valid = 1'b0;
        bus.write_data  = 16'h0;
        bus.write_strb  = 2'b00;
        bus.read_ready  = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_write_ready", bus.write_ready, 0);
        chk("rst_read_valid", bus.read_valid, 0);
        chk("rst_sram_ce", sram_ce, 0);
        chk("rst_sram_addr", sram_addr, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);
        chk("post_rst_sram_ce", sram_ce, 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            bus.req_valid   = 1'b1;
            bus.req_rw      = 1'b1;
            bus.req_addr    = vecs[i].addr;
            bus.req_burst   = 1'b0;
            bus.req_beats   = 14'h0;
            bus.write_valid = 1'b1;
            bus.write_data  = vecs[i].data;
            bus.write_strb  = vecs[i].strb;
            @(negedge clk);
            chk($sformatf("v%0d_idle_no_ce", i), sram_ce, 0);
            tick();
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_ce", i), sram_ce, 1);
            chk($sformatf("v%0d_we", i), sram_we, 1);
            chk($sformatf("v%0d_addr", i), sram_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_din", i), sram_din, vecs[i].data);
            chk($sformatf("v%0d_be", i), sram_be, vecs[i].strb);
            tick();
            bus.write_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_req_ready_back", i), bus.req_ready, 1);
            chk($sformatf("v%0d_mem", i), mem[vecs[i].exp_addr], vecs[i].exp_mem);
            tick();
        end

        clear_log();
        burst_write(32'h0, 6, 16'h0001, 3);
        chk("bw_count", log_addr.size(), 6);
        for (int k = 0; k < 6 && k < log_addr.size(); k++) begin
            chk($sformatf("bw_addr%0d", k), log_addr[k], k);
            chk($sformatf("bw_din%0d", k), log_din[k], k + 1);
            chk($sformatf("bw_we%0d", k), log_we[k], 1);
        end
        @(negedge clk);
        chk("bw_req_ready", bus.req_ready, 1);
        tick();

        burst_write(32'h0, 4, 16'h00A0, -1);
        tick();

        clear_log();
        bus.read_ready = 1'b0;
        start_req(1'b0, 32'h0, 4);
        repeat (10) tick();
        chk("br_stall_issued", log_addr.size(), 2);
        @(negedge clk);
        chk("br_stall_valid", bus.read_valid, 1);
        chk("br_stall_head", bus.read_data, 16'h00A0);
        tick();
        bus.read_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            if (bus.read_valid) begin
                rd[got] = bus.read_data;
                got++;
            end
            tick();
        end
        chk("br_words", got, 4);
        for (int k = 0; k < got && k < 4; k++)
            chk($sformatf("br_data%0d", k), rd[k], 16'h00A0 + 16'(k));
        repeat (3) tick();
        chk("br_total_reads", log_addr.size(), 4);
        @(negedge clk);
        chk("br_drained", bus.read_valid, 0);
        tick();

        clear_log();
        burst_write(32'd30, 3, 16'h0F00, -1);
        chk("wrap_count", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("wrap_addr0", log_addr[0], 15);
            chk("wrap_addr1", log_addr[1], 0);
            chk("wrap_addr2", log_addr[2], 1);
        end
        tick();
        bus.read_ready = 1'b1;
        start_req(1'b0, 32'd30, 3);
        got = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (bus.read_valid && got < 8) begin
                rd[got] = bus.read_data;
                got++;
            end
            tick();
        end
        chk("wrap_rd_words_in_time", got, 3);
        for (int k = 0; k < got && k < 3; k++)
            chk($sformatf("wrap_rd%0d", k), rd[k], 16'h0F00 + 16'(k));
        repeat (3) tick();

        clear_log();
        bus.read_ready = 1'b1;
        start_req(1'b0, 32'h0, 8);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sram_ce", sram_ce, 0);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_read_valid", bus.read_valid, 0);
        chk("mid_rst_idle", bus.req_ready, 1);
        repeat (5) tick();
        chk("mid_rst_issued", log_addr.size(), 2);
        @(negedge clk);
        chk("mid_rst_no_data", bus.read_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mam_sram_adapter.md
# mam_sram_adapter

Memory-side adapter that sits directly downstream of `osd_mam`. It consumes the MAM request, write-data and read-data handshakes and drives a single-port synchronous SRAM with one-cycle read latency. It turns byte-addressed single and burst requests into per-word SRAM accesses and applies write strobes as byte enables. Read data is buffered so that MAM back-pressure (`read_ready` low) never loses data.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width in bits; a multiple of 8 and at least 16.
- `ADDR_WIDTH`, 32: width of the MAM byte address.
- `BASE_ADDR`, 0: byte address that maps to SRAM word 0.
- `SRAM_AW`, 20: SRAM word-address width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  adapter accepts a request.
- `req_rw`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  start byte address.
- `req_burst`  in  1  1 = burst of `req_beats` words; 0 = single word.
- `req_beats`  in  14  burst length in words.
- `write_valid`  in  1  write word valid.
- `write_data`  in  DATA_WIDTH  write word.
- `write_strb`  in  DATA_WIDTH/8  byte strobes.
- `write_ready`  out  1  adapter accepts a write word.
- `read_valid`  out  1  read word valid.
- `read_data`  out  DATA_WIDTH  read word.
- `read_ready`  in  1  MAM accepts a read word.
- `sram_ce`  out  1  SRAM access this cycle.
- `sram_we`  out  1  SRAM write (valid only with `sram_ce`).
- `sram_addr`  out  SRAM_AW  SRAM word address.
- `sram_be`  out  DATA_WIDTH/8  byte enables.
- `sram_din`  out  DATA_WIDTH  SRAM write data.
- `sram_dout`  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access.

## Operation
- **FSM states:** IDLE, WRITE, READ.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch the request:
    - Word address = (`req_addr` − `BASE_ADDR`) >> log2(DATA_WIDTH/8), truncated to SRAM_AW bits. The SRAM address space wraps modulo 2^SRAM_AW.
    - Beat count = `req_burst ? req_beats : 1`. `req_burst` with `req_beats` = 0 is treated as 1 beat.
  - Go to WRITE if `req_rw` = 1, otherwise READ.
- **WRITE:**
  - `write_ready` = 1.
  - Each `write_valid && write_ready` cycle:
    - Assert `sram_ce` = `sram_we` = 1.
    - Drive `sram_addr` = current word address, `sram_din` = `write_data`, `sram_be` = `write_strb`.
    - Increment the word address (wrapping) and decrement the remaining-beat count.
  - After the last beat, go to IDLE.
- **READ:**
  - Issue one SRAM read (`sram_ce` = 1, `sram_we` = 0, `sram_be` all ones) per cycle while credit is available.
  - Credit rule: occupancy of the 2-entry read FIFO plus in-flight reads (0 or 1) < 2.
  - Data returned by the SRAM one cycle later is pushed into the FIFO.
  - After the last beat is issued, go to IDLE. Remaining read data drains independently of the FSM.
- **Read FIFO head:** the head drives `read_valid`/`read_data`. An entry is popped on `read_valid && read_ready`. A push and a pop in the same cycle are allowed.
- **Request acceptance during drain:** a new request may be accepted in IDLE while the FIFO still holds data. Word ordering of `read_data` is always issue order.
- **Reset mid-burst:** the FSM returns to IDLE, the FIFO is flushed, the in-flight flag is cleared, and remaining beats are discarded. No SRAM access is issued during the reset cycle.

## Timing
- **Reset values (outputs while `rst` = 1 and the first cycle after):** `req_ready` 0 during reset and 1 on the first cycle after; `write_ready` 0; `read_valid` 0; `sram_ce` 0; `sram_we` 0; `sram_addr`, `sram_be`, `sram_din` 0.
- **Request handshake:** `req_ready` depends only on state, never on `req_valid`. Request accept to first SRAM access is 1 cycle.
- **Write path:** `write_ready` and all `sram_*` write outputs are combinational from state and `write_valid`. Throughput is 1 word per cycle.
- **Read path:**
  - Read issue to `read_valid` is 2 cycles (SRAM latency plus FIFO register).
  - Throughput is 1 word per cycle while `read_ready` = 1.
  - With `read_ready` = 0, at most 2 words are read ahead, then issue stalls.
- **FIFO boundaries:** full blocks issue via the credit rule; empty means `read_valid` = 0. A simultaneous push and pop when full is not possible under the credit rule.
- **Bursts:** back-to-back requests incur 1 IDLE cycle between bursts.

## Structure
- **Shared package `mam_pkg`:**
  - typedef `mam_req_t` {rw, addr, burst, beats}.
  - localparam `MAM_BEATS_W` = 14.
- **Sub-module `mam_sram_rdfifo`:** 2-entry synchronous FIFO with push, pop, valid and count outputs, reset flush.
- **Top level:** contains the FSM, address/beat counters and the credit logic.

## Test plan
- Single write: `req_addr` 0x10, `req_rw` 1, `req_burst` 0, data 0x000f, strb 2'b11 -> one SRAM write at `sram_addr` 0x8 with `sram_din` 0x000f; `req_ready` returns 2 cycles after accept.
- Burst write with stall: 6 beats at address 0, `write_valid` held low for 3 cycles mid-burst -> writes of 0x0001..0x0006 at SRAM addresses 0..5, none during the stall.
- Burst read with back-pressure: 4 beats from address 0 preloaded with 0xA0..0xA3, `read_ready` low for 10 cycles -> exactly 2 SRAM reads issued during the stall, then 0xA0..0xA3 delivered in order with no loss or duplication.
- Address wrap: `SRAM_AW` = 4, burst of 3 beats at word 15 -> SRAM addresses 15, 0, 1.
- Partial strobe: `write_strb` 2'b01, data 0xBEEF -> `sram_be` 2'b01 and only the low byte changes in the SRAM model.
- Reset mid-read: `rst` asserted after 2 of 8 beats are issued -> `read_valid` is 0 on the next cycle, no further `sram_ce`, and the adapter is back in IDLE.
